// File: rtl/md_if.sv
// md_unit issue/result bundle.
// Controller drives master side, md_unit is the slave.
interface md_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             start;
  logic             hi_we;
  logic             lo_we;
  logic             flush;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div0;

  modport master (
    output a, b, op, start,
    output hi_we, lo_we, flush,
    input  busy, hi, lo, div0
  );

  modport slave (
    input  a, b, op, start,
    input  hi_we, lo_we, flush,
    output busy, hi, lo, div0
  );
endinterface

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO, MADD/MSUB,
// flush abort and divide-by-zero pulse.
module md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  md_if.slave bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int MAXC =
    (MUL_CYCLES > DIV_CYCLES) ?
    MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [2:0]       op_q;
  logic [W2-1:0]    p_q;
  logic             dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             div0_q;

  logic             sgn, is_div;
  logic             a_neg, b_neg, bz;
  logic [W2-1:0]    ax, bx, prod;
  logic [WIDTH-1:0] ua, ub, ubs, uq, ur;
  logic [WIDTH-1:0] q, r;
  logic [W2-1:0]    res, acc, nxt;
  logic             accept, last;

  // Operand prep: sign-extend for signed ops
  always_comb begin
    sgn    = ~bus.op[0];
    is_div = (bus.op[2:1] == 2'b01);
    a_neg  = sgn & bus.a[WIDTH-1];
    b_neg  = sgn & bus.b[WIDTH-1];
    bz     = (bus.b == '0);
    ax = {{WIDTH{a_neg}}, bus.a};
    bx = {{WIDTH{b_neg}}, bus.b};
    prod = ax * bx;
    ua  = a_neg ? -bus.a : bus.a;
    ub  = b_neg ? -bus.b : bus.b;
    ubs = bz ? WIDTH'(1) : ub;
    uq  = ua / ubs;
    ur  = ua % ubs;
    q = (a_neg ^ b_neg) ? -uq : uq;
    r = a_neg ? -ur : ur;
    res = is_div ? {r, q} : prod;
  end

  always_comb begin
    acc = {hi_q, lo_q};
    nxt = p_q;
    unique case (1'b1)
      op_q[2:1] == 2'b10: nxt = acc + p_q;
      op_q[2:1] == 2'b11: nxt = acc - p_q;
      default:            nxt = p_q;
    endcase
  end

  assign accept = (state_q == IDLE)
                & bus.start & ~bus.flush;
  assign last   = (state_q == RUN)
                & ~bus.flush
                & (cnt_q == CW'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (bus.flush || cnt_q == CW'(1))
              state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      p_q     <= '0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div0_q  <= 1'b0;
      if (accept) begin
        op_q  <= bus.op;
        p_q   <= res;
        dz_q  <= is_div & bz;
        cnt_q <= is_div ? CW'(DIV_CYCLES)
                        : CW'(MUL_CYCLES);
      end else if (state_q == RUN) begin
        if (bus.flush) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q - CW'(1);
          if (last) begin
            // Divide by zero leaves HI/LO alone
            if (dz_q) begin
              div0_q <= 1'b1;
            end else begin
              hi_q <= nxt[W2-1:WIDTH];
              lo_q <= nxt[WIDTH-1:0];
            end
          end
        end
      end else if (!bus.flush) begin
        if (bus.hi_we) hi_q <= bus.a;
        if (bus.lo_we) lo_q <= bus.a;
      end
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.div0 = div0_q;
endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit.
`timescale 1ns/1ps
module tb_md_unit;
  localparam logic [2:0] MULT  = 3'd0;
  localparam logic [2:0] MULTU = 3'd1;
  localparam logic [2:0] DIV   = 3'd2;
  localparam logic [2:0] DIVU  = 3'd3;
  localparam logic [2:0] MADDU = 3'd5;
  localparam logic [2:0] MSUBU = 3'd7;

  logic clk = 1'b0;
  logic reset;
  int   vecs = 0;
  int   miss = 0;
  logic d0;

  md_if #(.WIDTH(32)) md ();

  md_unit #(
    .WIDTH(32),
    .MUL_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(md)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic issue(
    input logic [2:0]  o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    md.op    = o;
    md.a     = x;
    md.b     = y;
    md.start = 1'b1;
    step();
    md.start = 1'b0;
  endtask

  task automatic wait_done(
    input int    exp_n,
    input string tag
  );
    int n;
    n = 0;
    while (md.busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
    check({tag, "_cycles"}, 64'(n), 64'(exp_n));
    d0 = md.div0;
  endtask

  task automatic hilo(
    input string       tag,
    input logic [31:0] eh,
    input logic [31:0] el
  );
    check({tag, "_hi"}, 64'(md.hi), 64'(eh));
    check({tag, "_lo"}, 64'(md.lo), 64'(el));
  endtask

  initial begin
    md.a = '0; md.b = '0; md.op = '0;
    md.start = 0; md.hi_we = 0;
    md.lo_we = 0; md.flush = 0;
    reset = 1'b1;
    step();
    step();
    check("rst_busy", 64'(md.busy), 64'd0);
    check("rst_div0", 64'(md.div0), 64'd0);
    hilo("rst", 32'h0, 32'h0);
    reset = 1'b0;
    step();

    issue(MULT, 32'hFFFFFFFD, 32'h7);
    wait_done(5, "mult");
    hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFEB);
    check("mult_div0", 64'(d0), 64'd0);

    issue(MULTU, 32'hFFFFFFFD, 32'h7);
    wait_done(5, "multu");
    hilo("multu", 32'h6, 32'hFFFFFFEB);

    issue(DIVU, 32'd100, 32'd7);
    wait_done(10, "divu");
    hilo("divu", 32'h2, 32'hE);

    issue(DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(10, "div");
    hilo("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

    issue(DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(10, "divmin");
    hilo("divmin", 32'h0, 32'h80000000);

    md.hi_we = 1; md.a = 32'h0;
    step();
    md.hi_we = 0; md.lo_we = 1;
    md.a = 32'hFFFFFFFF;
    step();
    md.lo_we = 0;
    hilo("mthilo", 32'h0, 32'hFFFFFFFF);

    issue(MADDU, 32'd1, 32'd1);
    wait_done(5, "maddu");
    hilo("maddu", 32'h1, 32'h0);

    issue(MSUBU, 32'd1, 32'd1);
    wait_done(5, "msubu");
    hilo("msubu", 32'h0, 32'hFFFFFFFF);

    md.hi_we = 1; md.lo_we = 1;
    md.a = 32'h55;
    step();
    hilo("both_we", 32'h55, 32'h55);
    md.lo_we = 0; md.a = 32'h12345678;
    step();
    md.hi_we = 0; md.lo_we = 1;
    md.a = 32'h9ABCDEF0;
    step();
    md.lo_we = 0;
    hilo("preset", 32'h12345678, 32'h9ABCDEF0);

    // div0 with a stray start mid-run
    issue(DIV, 32'd5, 32'd0);
    begin
      int n;
      n = 0;
      while (md.busy === 1'b1 && n < 40) begin
        n++;
        md.start = (n == 4);
        step();
      end
      md.start = 1'b0;
      check("dz_cycles", 64'(n), 64'd10);
      d0 = md.div0;
    end
    check("dz_div0", 64'(d0), 64'd1);
    hilo("dz", 32'h12345678, 32'h9ABCDEF0);
    step();
    check("dz_pulse", 64'(md.div0), 64'd0);
    check("dz_idle", 64'(md.busy), 64'd0);

    issue(DIVU, 32'd100, 32'd7);
    step();
    step();
    md.flush = 1;
    step();
    md.flush = 0;
    check("fl_busy", 64'(md.busy), 64'd0);
    repeat (12) step();
    hilo("fl", 32'h12345678, 32'h9ABCDEF0);
    check("fl_div0", 64'(md.div0), 64'd0);

    issue(MULT, 32'd2, 32'd3);
    wait_done(5, "after_fl");
    hilo("after_fl", 32'h0, 32'h6);

    issue(MULTU, 32'd4, 32'd4);
    repeat (4) step();
    md.flush = 1;
    step();
    md.flush = 0;
    check("fl_last_busy", 64'(md.busy), 64'd0);
    repeat (3) step();
    hilo("fl_last", 32'h0, 32'h6);

    md.flush = 1;
    issue(MULT, 32'd9, 32'd9);
    md.flush = 0;
    check("fl_start", 64'(md.busy), 64'd0);

    md.flush = 1; md.hi_we = 1;
    md.a = 32'hAAAA;
    step();
    md.flush = 0; md.hi_we = 0;
    hilo("fl_we", 32'h0, 32'h6);

    issue(MULT, 32'd3, 32'd5);
    step();
    reset = 1;
    step();
    reset = 0;
    check("rr_busy", 64'(md.busy), 64'd0);
    hilo("rr", 32'h0, 32'h0);
    repeat (8) step();
    hilo("rr_late", 32'h0, 32'h0);

    md.hi_we = 1;
    issue(MULTU, 32'd7, 32'd9);
    md.hi_we = 0;
    wait_done(5, "we_start");
    hilo("we_start", 32'h0, 32'h3F);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end
endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit for the Execute stage. It replaces the fixed 32-bit MD block and adds configurable width and latency, multiply-accumulate/subtract, a flush abort, and divide-by-zero reporting. The controller issues one operation per `start` pulse and holds the pipeline while `busy` is high. HI/LO are architectural registers owned by this block.

## Interface
- `WIDTH`, 32: operand and HI/LO width (≥ 2).
- `MUL_CYCLES`, 5: busy cycles for multiply-class ops (≥ 1).
- `DIV_CYCLES`, 10: busy cycles for divide-class ops (≥ 1).

- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `a` in WIDTH: operand 1 (rs); dividend for divide ops.
- `b` in WIDTH: operand 2 (rt); divisor for divide ops.
- `op` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
- `start` in 1: one-cycle issue strobe.
- `hi_we` in 1: MTHI, writes `a` to HI.
- `lo_we` in 1: MTLO, writes `a` to LO.
- `flush` in 1: abort the in-flight operation (exception/cancel).
- `busy` out 1: operation in flight.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.
- `div0` out 1: one-cycle pulse when a DIV/DIVU with `b`=0 completes.

## Operation
- Reset: `hi`=0, `lo`=0, `busy`=0, `div0`=0. The cycle counter clears and any in-flight op is discarded.
- States: IDLE and RUN.
  - IDLE → RUN on an edge with `start`=1, `flush`=0, `reset`=0. At that edge `a`, `b`, `op` are latched, the counter loads the op latency, and the result is computed from the latched values.
  - RUN: the counter decrements each cycle.
  - RUN → IDLE on the edge that ends the last busy cycle. HI/LO are committed on that same edge.
- Arithmetic (P = 2·WIDTH-bit product):
  - MULT/MULTU: {hi,lo} = signed/unsigned a×b.
  - MADD(U): {hi,lo} = {hi,lo} + P.
  - MSUB(U): {hi,lo} = {hi,lo} − P.
  - Accumulate wraps modulo 2^(2·WIDTH) and uses the HI/LO values current at commit.
- DIVU: lo = a/b, hi = a%b, unsigned.
- DIV: quotient truncates toward zero; remainder takes the sign of the dividend. For MIN/−1 the result is lo = MIN, hi = 0 (no trap).
- Divide by zero: the op runs its full DIV_CYCLES. HI/LO stay unchanged, and `div0` goes high for exactly the cycle after commit.
- `start` while `busy`: ignored; the in-flight op is unaffected.
- `hi_we`/`lo_we`:
  - In IDLE without `start`: write `a` into HI/LO at the edge. Both may be asserted together.
  - In RUN: ignored.
  - Same cycle as an accepted `start`: ignored; `start` has priority.
- `flush`:
  - In RUN: at the next edge `busy`=0, state is IDLE, and there is no commit and no `div0`.
  - Same cycle as `start`: the start is dropped.
  - In IDLE: no effect. It also blocks `hi_we`/`lo_we` that cycle.
- Reset has priority over flush, which has priority over start and the write enables.

## Timing
- `start` sampled at edge T: `busy`=1 in cycles T+1 … T+N, where N = MUL_CYCLES or DIV_CYCLES.
- Edge T+N commits HI/LO. New values are visible and `busy`=0 in cycle T+N+1.
- A back-to-back `start` is accepted in cycle T+N+1, so throughput is one op per N+1 cycles.
- `hi_we`/`lo_we` latency is 1: the value is visible the cycle after.
- `hi` and `lo` are pure register outputs with no combinational path from inputs.
- `div0` is high only in cycle T+N+1.
- `busy` falls in the cycle after `flush` is sampled. A flush on the final busy cycle still suppresses the commit.

## Test plan
- MULT a=FFFFFFFD, b=00000007 → `busy` high 5 cycles, then hi=FFFFFFFF, lo=FFFFFFEB. MULTU with the same operands → hi=00000006, lo=FFFFFFEB.
- DIVU a=100, b=7 → `busy` high 10 cycles, lo=0000000E, hi=00000002. DIV a=FFFFFFF9 (−7), b=2 → lo=FFFFFFFD, hi=FFFFFFFF. DIV a=80000000, b=FFFFFFFF → lo=80000000, hi=0.
- MTHI 0, MTLO FFFFFFFF, then MADDU a=1, b=1 → hi=00000001, lo=00000000. MSUBU a=1, b=1 afterward → hi=0, lo=FFFFFFFF.
- DIV with b=0 and prior hi=12345678, lo=9ABCDEF0 → 10 busy cycles, HI/LO unchanged, `div0` high for one cycle. A `start` pulsed mid-run is ignored: total busy stays 10.
- DIVU started, `flush` on busy cycle 3 → `busy`=0 the next cycle, HI/LO unchanged, no `div0`. An immediate MULT start is then accepted normally.
- `reset` asserted on busy cycle 2 of MULT → next cycle busy=0, hi=lo=0, no later commit. `hi_we` in the same cycle as an accepted `start` → HI takes only the op result.
